// File: rtl/simd_pkg.sv
// Shared types and constants for the SIMD command sequencer.
package simd_pkg;

  localparam int unsigned N_VREG = 32;
  localparam int unsigned VREG_W = $clog2(N_VREG);
  localparam int unsigned ROW_W  = 256;
  localparam int unsigned OP_W   = 2;
  localparam int unsigned MUX_W  = 2;

  localparam logic [OP_W-1:0] SIMD_OP_SIMD = 2'b00;
  localparam logic [OP_W-1:0] SIMD_OP_VADD = 2'b01;
  localparam logic [OP_W-1:0] SIMD_OP_RELU = 2'b10;
  localparam logic [OP_W-1:0] SIMD_OP_ILL  = 2'b11;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DRAIN, DONE} state_e;

  typedef struct packed {
    logic relu;
    logic vadd;
    logic simd;
  } op_en_t;

  // One-hot op enables; the illegal op decodes to all zero.
  function automatic op_en_t op_decode(input logic [OP_W-1:0] op);
    op_en_t en;
    en = '0;
    case (op)
      SIMD_OP_SIMD: en.simd = 1'b1;
      SIMD_OP_VADD: en.vadd = 1'b1;
      SIMD_OP_RELU: en.relu = 1'b1;
      default:      en = '0;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/simd_rd_track.sv
// Tracks regfile reads in flight: a RD_LAT-deep valid pipe plus outstanding count.
module simd_rd_track #(
  parameter int unsigned RD_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic flush,
  output logic pop,
  output logic empty
);

  localparam int unsigned CNT_W = $clog2(RD_LAT + 1);

  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    vld_d    = vld_q << 1;
    vld_d[0] = push;
  end

  assign pop   = vld_q[RD_LAT-1];
  assign cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
  // True when nothing will remain outstanding after this cycle.
  assign empty = (cnt_q == CNT_W'(pop)) && !push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      vld_q <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/simd_issue_ctrl.sv
// Vector command sequencer: issues one regfile read per row, forwards the
// returned rows with destination index and op enables, then drains and signals done.
module simd_issue_ctrl
  import simd_pkg::*;
#(
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned DRAIN_CYC = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [VREG_W-1:0] cmd_src,
  input  logic [VREG_W-1:0] cmd_dst,
  input  logic [VREG_W-1:0] cmd_len,
  input  logic [MUX_W-1:0]  cmd_mux,
  input  logic              i_stall,
  output logic              rf_rd_en,
  output logic [VREG_W-1:0] rf_rd_addr,
  input  logic [ROW_W-1:0]  rf_rd_data,
  output logic [ROW_W-1:0]  o_data,
  output logic              o_data_v,
  output logic [VREG_W-1:0] o_rf_idx,
  output logic [MUX_W-1:0]  o_rf_mux,
  output logic              o_en_simd,
  output logic              o_en_vadd,
  output logic              o_en_relu,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam int unsigned DRN_W = 4;

  state_e              state_q;
  logic [VREG_W-1:0]   rd_addr_q, rd_cnt_q, len_q, idx_nxt_q, idx_q;
  logic [DRN_W-1:0]    drain_q;
  op_en_t              en_q;
  logic [MUX_W-1:0]    mux_q;
  logic [ROW_W-1:0]    data_q;
  logic                dv_q, err_q;
  logic                accept, rd_fire, pop, empty;

  assign cmd_ready = (state_q == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  // Stall gates the read in the same cycle, including the last one.
  assign rd_fire   = (state_q == ISSUE) && !i_stall;

  simd_rd_track #(.RD_LAT(RD_LAT)) u_track (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rd_fire),
    .flush (accept),
    .pop   (pop),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rd_addr_q <= '0;
      rd_cnt_q  <= '0;
      len_q     <= '0;
      idx_nxt_q <= '0;
      idx_q     <= '0;
      drain_q   <= '0;
      en_q      <= '0;
      mux_q     <= '0;
      data_q    <= '0;
      dv_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      dv_q  <= 1'b0;
      // Forward returning rows regardless of FSM state or stall.
      if (pop) begin
        data_q    <= rf_rd_data;
        dv_q      <= 1'b1;
        idx_q     <= idx_nxt_q;
        idx_nxt_q <= idx_nxt_q + VREG_W'(1);
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (cmd_op == SIMD_OP_ILL) begin
              err_q <= 1'b1;
            end else begin
              state_q   <= ISSUE;
              len_q     <= cmd_len;
              rd_addr_q <= cmd_src;
              rd_cnt_q  <= '0;
              idx_nxt_q <= cmd_dst;
              en_q      <= op_decode(cmd_op);
              mux_q     <= cmd_mux;
            end
          end
        end
        ISSUE: begin
          if (!i_stall) begin
            rd_addr_q <= rd_addr_q + VREG_W'(1);
            rd_cnt_q  <= rd_cnt_q + VREG_W'(1);
            if (rd_cnt_q == len_q) state_q <= WAIT;
          end
        end
        WAIT: begin
          if (empty) begin
            state_q <= DRAIN;
            drain_q <= '0;
          end
        end
        DRAIN: begin
          if (drain_q == DRN_W'(DRAIN_CYC - 1)) begin
            state_q <= DONE;
            en_q    <= '0;
            mux_q   <= '0;
          end else begin
            drain_q <= drain_q + DRN_W'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rf_rd_en   = rd_fire;
  assign rf_rd_addr = rd_addr_q;
  assign o_data     = data_q;
  assign o_data_v   = dv_q;
  assign o_rf_idx   = idx_q;
  assign o_rf_mux   = mux_q;
  assign o_en_simd  = en_q.simd;
  assign o_en_vadd  = en_q.vadd;
  assign o_en_relu  = en_q.relu;
  assign o_busy     = (state_q != IDLE);
  assign o_done     = (state_q == DONE);
  assign o_err      = err_q;

endmodule

// File: tb/tb_simd_issue_ctrl.sv
// Directed bench for simd_issue_ctrl: instance 0 with RD_LAT=1, instance 1 with
// RD_LAT=2, both driven by the same command stream.
module tb_simd_issue_ctrl;

  logic       clk, rst_n, cmd_valid, i_stall;
  logic [1:0] cmd_op, cmd_mux;
  logic [4:0] cmd_src, cmd_dst, cmd_len;

  wire [1:0]   cmd_ready, rd_en, dv, busy, done, err;
  wire [4:0]   rd_addr [2];
  wire [4:0]   rf_idx  [2];
  wire [1:0]   rf_mux  [2];
  wire [255:0] o_data  [2];
  wire [2:0]   en      [2];
  wire [255:0] rfd0, rfd1;

  logic [4:0] ap0, ap1a, ap1b;
  int cyc;
  int n_chk, n_err;

  int          rd_a [2][64], rd_c [2][64], out_i [2][64], out_c [2][64], done_c [2][64];
  logic [255:0] out_d [2][64];
  logic [2:0]  out_en [2][64], done_en [2][64];
  logic [1:0]  out_mx [2][64];
  int tot_rd [2], tot_out [2], tot_done [2], tot_err [2], inv_bad [2];
  int b_rd [2], b_out [2], b_done [2], b_err [2];

  function automatic logic [255:0] row(input logic [4:0] a);
    return {8{8'hC3, 3'b000, a, 8'(a) ^ 8'h5A, 8'h96}};
  endfunction

  simd_issue_ctrl #(.RD_LAT(1), .DRAIN_CYC(3)) u0 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[0]),
    .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
    .cmd_mux(cmd_mux), .i_stall(i_stall), .rf_rd_en(rd_en[0]), .rf_rd_addr(rd_addr[0]),
    .rf_rd_data(rfd0), .o_data(o_data[0]), .o_data_v(dv[0]), .o_rf_idx(rf_idx[0]),
    .o_rf_mux(rf_mux[0]), .o_en_simd(en[0][0]), .o_en_vadd(en[0][1]), .o_en_relu(en[0][2]),
    .o_busy(busy[0]), .o_done(done[0]), .o_err(err[0])
  );

  simd_issue_ctrl #(.RD_LAT(2), .DRAIN_CYC(3)) u1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[1]),
    .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
    .cmd_mux(cmd_mux), .i_stall(i_stall), .rf_rd_en(rd_en[1]), .rf_rd_addr(rd_addr[1]),
    .rf_rd_data(rfd1), .o_data(o_data[1]), .o_data_v(dv[1]), .o_rf_idx(rf_idx[1]),
    .o_rf_mux(rf_mux[1]), .o_en_simd(en[1][0]), .o_en_vadd(en[1][1]), .o_en_relu(en[1][2]),
    .o_busy(busy[1]), .o_done(done[1]), .o_err(err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Regfile model: data for an address appears RD_LAT cycles after the read.
  always @(posedge clk) begin
    ap0  <= rd_addr[0];
    ap1a <= rd_addr[1];
    ap1b <= ap1a;
  end
  assign rfd0 = row(ap0);
  assign rfd1 = row(ap1b);

  // Event logger, sampled on the falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rd_en[i] === 1'b1) begin
        rd_a[i][tot_rd[i] % 64] = int'(rd_addr[i]);
        rd_c[i][tot_rd[i] % 64] = cyc;
        tot_rd[i]++;
      end
      if (dv[i] === 1'b1) begin
        out_i[i][tot_out[i] % 64]  = int'(rf_idx[i]);
        out_c[i][tot_out[i] % 64]  = cyc;
        out_d[i][tot_out[i] % 64]  = o_data[i];
        out_en[i][tot_out[i] % 64] = en[i];
        out_mx[i][tot_out[i] % 64] = rf_mux[i];
        tot_out[i]++;
      end
      if (done[i] === 1'b1) begin
        done_c[i][tot_done[i] % 64]  = cyc;
        done_en[i][tot_done[i] % 64] = en[i];
        tot_done[i]++;
      end
      if (err[i] === 1'b1) tot_err[i]++;
      if (cmd_ready[i] !== !busy[i]) inv_bad[i]++;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    for (int i = 0; i < 2; i++) begin
      b_rd[i] = tot_rd[i]; b_out[i] = tot_out[i];
      b_done[i] = tot_done[i]; b_err[i] = tot_err[i];
    end
  endtask

  task automatic start(input logic [1:0] op, input logic [4:0] s, input logic [4:0] d,
                       input logic [4:0] l, input logic [1:0] m, output int a);
    @(negedge clk);
    chk("start.ready", int'(cmd_ready), 3);
    cmd_op = op; cmd_src = s; cmd_dst = d; cmd_len = l; cmd_mux = m;
    cmd_valid = 1'b1;
    a = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    @(negedge clk);
    while (busy !== 2'b00 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk({tag, ".idle"}, int'(busy), 0);
    repeat (2) @(negedge clk);
  endtask

  // Compare logged reads/rows/done of one instance against a hand-derived timeline.
  task automatic verify(input string tag, input int i, input int a, input int src,
                        input int dst, input int nrows, input int lat, input int stall_k,
                        input int gap, input logic [2:0] en_exp, input logic [1:0] mux_exp);
    int rc, oc, ix;
    string p;
    p = $sformatf("%s.u%0d", tag, i);
    chk({p, ".n_rd"},   tot_rd[i] - b_rd[i], nrows);
    chk({p, ".n_out"},  tot_out[i] - b_out[i], nrows);
    chk({p, ".n_done"}, tot_done[i] - b_done[i], 1);
    chk({p, ".n_err"},  tot_err[i] - b_err[i], 0);
    oc = 0;
    for (int k = 0; k < nrows && k < 64; k++) begin
      rc = a + 1 + k + ((k >= stall_k) ? gap : 0);
      oc = rc + lat + 1;
      chk($sformatf("%s.rd_addr%0d", p, k), rd_a[i][(b_rd[i] + k) % 64], (src + k) % 32);
      chk($sformatf("%s.rd_cyc%0d", p, k),  rd_c[i][(b_rd[i] + k) % 64], rc);
      ix = (b_out[i] + k) % 64;
      chk($sformatf("%s.idx%0d", p, k),     out_i[i][ix], (dst + k) % 32);
      chk($sformatf("%s.out_cyc%0d", p, k), out_c[i][ix], oc);
      chk($sformatf("%s.data%0d", p, k),    int'(out_d[i][ix] === row(5'((src + k) % 32))), 1);
      chk($sformatf("%s.en%0d", p, k),      int'(out_en[i][ix]), int'(en_exp));
      chk($sformatf("%s.mux%0d", p, k),     int'(out_mx[i][ix]), int'(mux_exp));
    end
    chk({p, ".done_cyc"}, done_c[i][b_done[i] % 64], oc + 3);
    chk({p, ".done_en"},  int'(done_en[i][b_done[i] % 64]), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    int acc_n [2];
    int acc_c [2][4];
    n_chk = 0; n_err = 0;
    rst_n = 1'b0; cmd_valid = 1'b0; i_stall = 1'b0;
    cmd_op = '0; cmd_src = '0; cmd_dst = '0; cmd_len = '0; cmd_mux = '0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst.cmd_ready", int'(cmd_ready), 3);
    chk("rst.busy", int'(busy), 0);
    chk("rst.rd_en", int'(rd_en), 0);
    chk("rst.data_v", int'(dv), 0);
    chk("rst.done", int'(done), 0);
    chk("rst.err", int'(err), 0);
    chk("rst.en0", int'(en[0]), 0);
    chk("rst.en1", int'(en[1]), 0);
    chk("rst.mux0", int'(rf_mux[0]), 0);
    chk("rst.idx1", int'(rf_idx[1]), 0);
    chk("rst.data0", int'(o_data[0] === 256'd0), 1);
    rst_n = 1'b1;

    // vadd src=4 dst=10 len=2
    clear_logs();
    start(2'b01, 5'd4, 5'd10, 5'd2, 2'b10, a);
    chk("t1.ready_busy", int'(cmd_ready), 0);
    chk("t1.busy", int'(busy), 3);
    wait_idle("t1");
    verify("t1", 0, a, 4, 10, 3, 1, 99, 0, 3'b010, 2'b10);
    verify("t1", 1, a, 4, 10, 3, 2, 99, 0, 3'b010, 2'b10);

    // Address and index wrap: relu src=30 dst=31 len=3
    clear_logs();
    start(2'b10, 5'd30, 5'd31, 5'd3, 2'b01, a);
    wait_idle("t2");
    verify("t2", 0, a, 30, 31, 4, 1, 99, 0, 3'b100, 2'b01);
    verify("t2", 1, a, 30, 31, 4, 2, 99, 0, 3'b100, 2'b01);

    // Stall for 3 cycles after the second read
    clear_logs();
    start(2'b00, 5'd12, 5'd20, 5'd3, 2'b00, a);
    @(negedge clk);
    @(posedge clk); #1 i_stall = 1'b1;
    repeat (3) @(posedge clk);
    #1 i_stall = 1'b0;
    wait_idle("t3");
    verify("t3", 0, a, 12, 20, 4, 1, 2, 3, 3'b001, 2'b00);
    verify("t3", 1, a, 12, 20, 4, 2, 2, 3, 3'b001, 2'b00);

    // Illegal op, then a legal command
    clear_logs();
    start(2'b11, 5'd7, 5'd7, 5'd4, 2'b00, a);
    chk("t4.err_pulse", int'(err), 3);
    chk("t4.busy", int'(busy), 0);
    chk("t4.ready", int'(cmd_ready), 3);
    chk("t4.rd_en", int'(rd_en), 0);
    @(negedge clk);
    chk("t4.err_drop", int'(err), 0);
    repeat (4) @(negedge clk);
    chk("t4.no_rd0", tot_rd[0] - b_rd[0], 0);
    chk("t4.no_rd1", tot_rd[1] - b_rd[1], 0);
    clear_logs();
    start(2'b00, 5'd0, 5'd5, 5'd1, 2'b11, a);
    wait_idle("t4b");
    verify("t4b", 0, a, 0, 5, 2, 1, 99, 0, 3'b001, 2'b11);
    verify("t4b", 1, a, 0, 5, 2, 2, 99, 0, 3'b001, 2'b11);

    // Reset during ISSUE with two reads in flight
    clear_logs();
    start(2'b01, 5'd8, 5'd0, 5'd5, 2'b00, a);
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b0;
    clear_logs();
    #1;
    chk("t5.busy", int'(busy), 0);
    chk("t5.rd_en", int'(rd_en), 0);
    chk("t5.ready", int'(cmd_ready), 3);
    chk("t5.data_v", int'(dv), 0);
    chk("t5.en0", int'(en[0]), 0);
    chk("t5.en1", int'(en[1]), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("t5.no_out0", tot_out[0] - b_out[0], 0);
    chk("t5.no_out1", tot_out[1] - b_out[1], 0);
    chk("t5.no_done0", tot_done[0] - b_done[0], 0);
    chk("t5.no_done1", tot_done[1] - b_done[1], 0);
    clear_logs();
    start(2'b01, 5'd3, 5'd7, 5'd0, 2'b01, a);
    wait_idle("t5b");
    verify("t5b", 0, a, 3, 7, 1, 1, 99, 0, 3'b010, 2'b01);
    verify("t5b", 1, a, 3, 7, 1, 2, 99, 0, 3'b010, 2'b01);

    // cmd_valid held high across two commands
    clear_logs();
    @(negedge clk);
    cmd_op = 2'b00; cmd_src = 5'd1; cmd_dst = 5'd2; cmd_len = 5'd1; cmd_mux = 2'b00;
    cmd_valid = 1'b1;
    a = cyc;
    acc_n[0] = 0; acc_n[1] = 0;
    for (int t = 0; t < 100; t++) begin
      for (int i = 0; i < 2; i++) begin
        if (cmd_ready[i] === 1'b1) begin
          if (acc_n[i] < 4) acc_c[i][acc_n[i]] = cyc;
          acc_n[i]++;
        end
      end
      if (acc_n[0] >= 2 && acc_n[1] >= 2) break;
      @(negedge clk);
    end
    @(posedge clk); #1 cmd_valid = 1'b0;
    wait_idle("t6");
    chk("t6.acc_n0", acc_n[0], 2);
    chk("t6.acc_n1", acc_n[1], 2);
    chk("t6.acc0_first", acc_c[0][0] - a, 0);
    chk("t6.acc0_second", acc_c[0][1] - a, 8);
    chk("t6.acc1_second", acc_c[1][1] - a, 9);
    chk("t6.n_done0", tot_done[0] - b_done[0], 2);
    chk("t6.n_done1", tot_done[1] - b_done[1], 2);
    chk("t6.n_out0", tot_out[0] - b_out[0], 4);
    chk("t6.n_out1", tot_out[1] - b_out[1], 4);
    chk("t6.done0_a", done_c[0][b_done[0] % 64] - a, 7);
    chk("t6.done0_b", done_c[0][(b_done[0] + 1) % 64] - a, 15);
    chk("t6.done1_a", done_c[1][b_done[1] % 64] - a, 8);
    chk("t6.done1_b", done_c[1][(b_done[1] + 1) % 64] - a, 17);
    chk("t6.idx0_last", out_i[0][(b_out[0] + 3) % 64], 3);

    // cmd_ready must be the inverse of busy on every sampled cycle
    chk("inv.ready_busy0", inv_bad[0], 0);
    chk("inv.ready_busy1", inv_bad[1], 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/simd_issue_ctrl.md
Name: simd_issue_ctrl

Overview:
- Command sequencer for the vector SIMD unit; sits between the instruction decoder and the SIMD input pre-register.
- Accepts one vector command: op, source and destination vreg bases, row count.
- Issues one 32-byte vector-regfile read per row and forwards the returned rows with per-row destination index, mux select and op enables.
- Waits a fixed drain time for the SIMD pipeline to empty, then pulses done.

Parameters:
RD_LAT, 1, regfile read latency in cycles (rf_rd_en to rf_rd_data valid); legal 1..4
DRAIN_CYC, 3, cycles between the last forwarded row and o_done; legal 1..15
N_VREG, 32, vreg count; index width is log2(N_VREG)=5

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
cmd_op  in  2  00 simd, 01 vadd, 10 relu, 11 illegal
cmd_src  in  5  first source vreg
cmd_dst  in  5  first destination vreg
cmd_len  in  5  row count minus 1 (0 gives 1 row, 31 gives 32 rows)
cmd_mux  in  2  regfile write mux select passed through
i_stall  in  1  downstream backpressure; blocks new reads
rf_rd_en  out  1  regfile read strobe
rf_rd_addr  out  5  regfile read address
rf_rd_data  in  256  read data, valid RD_LAT cycles after rf_rd_en
o_data  out  256  row to SIMD input register
o_data_v  out  1  o_data valid
o_rf_idx  out  5  destination vreg of this row
o_rf_mux  out  2  latched cmd_mux
o_en_simd / o_en_vadd / o_en_relu  out  1 each  op enables, one-hot, held for the whole command
o_busy  out  1  state != IDLE
o_done  out  1  one-cycle completion pulse
o_err  out  1  one-cycle pulse on illegal op

Behaviour:
- Reset values: all outputs 0 except cmd_ready=1. Internal read-valid shift register, counters and latched command are cleared.
- States:
  - IDLE: cmd_ready=1. On accept, latch the command. Op 11 pulses o_err next cycle and stays in IDLE with no reads. Otherwise go to ISSUE.
  - ISSUE: each cycle with !i_stall, rf_rd_en=1 and rf_rd_addr=(src+k) mod 32, then k++. After read k==len, go to WAIT.
  - WAIT: stay until the outstanding-read count is 0, then go to DRAIN.
  - DRAIN: count DRAIN_CYC cycles, then go to DONE.
  - DONE: o_done=1 for one cycle, enables drop to 0, return to IDLE. The next command may be accepted the cycle after DONE.
- Forwarding:
  - A RD_LAT-deep valid shift register tracks reads. When it emits, register o_data=rf_rd_data and o_data_v=1; output latency is RD_LAT+1 from rf_rd_en.
  - o_rf_idx=(dst+j) mod 32, where j counts forwarded rows.
  - o_data holds its value when o_data_v=0.
- Stall:
  - i_stall gates only new reads; reads already in flight still return and forward. Downstream must absorb up to RD_LAT rows after asserting stall.
  - Stall during WAIT/DRAIN has no effect.
- Enables: o_en_* and o_rf_mux are asserted from the cycle after accept until DONE, including DRAIN.
- Wrap: src+k and dst+j wrap modulo 32 (src=30, len=3 reads 30,31,0,1).
- Simultaneous events: cmd_valid during busy is ignored (cmd_ready=0). A stall arriving on the cycle of the last read still blocks that read.
- Reset mid-operation: return to IDLE at once. In-flight returns are discarded, and no o_done or o_data_v is produced.

Decomposition:
- Shared package simd_pkg:
  - op encodings SIMD_OP_SIMD/VADD/RELU/ILL
  - VREG_W=5, ROW_W=256
  - state enum {IDLE, ISSUE, WAIT, DRAIN, DONE}
- Sub-module simd_rd_track: RD_LAT valid shift register plus outstanding counter (inputs push and flush; outputs pop and empty).

Test Plan:
- RD_LAT=1, op=vadd, src=4, dst=10, len=2, no stall:
  - rf_rd_addr 4,5,6 on cycles 1-3.
  - o_data_v on cycles 3-5 with o_rf_idx 10,11,12 and o_en_vadd=1.
  - o_done 3 cycles after the last row.
- src=30, dst=31, len=3 -> read addrs 30,31,0,1; o_rf_idx 31,0,1,2.
- RD_LAT=2, i_stall high for 3 cycles after the second read:
  - No rf_rd_en while stalled.
  - Two in-flight rows still forwarded.
  - 4 rows total with consecutive idx; o_done once.
- cmd_op=11 -> o_err pulse, no rf_rd_en, cmd_ready stays 1; a following legal command completes normally.
- rst_n low during ISSUE with 2 reads in flight -> outputs 0 immediately, no o_data_v after release; a new command with len=0 yields exactly 1 row.
- Back-to-back cmd_valid held high across two commands -> second accepted only after o_done; cmd_ready=0 throughout busy.
